// File: rtl/regbank_pkg.sv
// Shared types and parameter defaults for the multi-port register bank.
package regbank_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DW_DEF       = 32;
  localparam int DEPTH_DEF    = 32;
  localparam int NRD_DEF      = 2;
  localparam int ZERO_REG_DEF = 1;

endpackage

// File: rtl/regbank_mp_if.sv
// Decode-stage access bus of the register bank: read ports, two write ports, issue marking.
interface regbank_mp_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
);

  // No valid/ready handshake: enables are sampled on every rising edge while
  // ready=1 and silently dropped while ready=0; reads are purely combinational.
  logic                clr_req;
  logic                ready;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr0_en;
  logic [AW-1:0]       wr0_addr;
  logic [DW-1:0]       wr0_data;
  logic                wr1_en;
  logic [AW-1:0]       wr1_addr;
  logic [DW-1:0]       wr1_data;
  logic                set_busy;
  logic [AW-1:0]       set_addr;

  modport master (
    output clr_req, rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, set_busy, set_addr,
    input  ready, rd_data, rd_busy
  );

  modport slave (
    input  clr_req, rd_addr, wr0_en, wr0_addr, wr0_data,
           wr1_en, wr1_addr, wr1_data, set_busy, set_addr,
    output ready, rd_data, rd_busy
  );

endinterface

// File: rtl/regbank_scoreboard.sv
// Per-register pending bits: set on producer issue, cleared by the producing write.
module regbank_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_all,
  input  logic              en,
  input  logic              set_busy,
  input  logic [AW-1:0]     set_addr,
  input  logic              wr0_eff,
  input  logic [AW-1:0]     wr0_addr,
  input  logic              wr1_eff,
  input  logic [AW-1:0]     wr1_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             set_v;

  assign set_v = en && set_busy && !((ZERO_REG != 0) && (set_addr == '0));

  // Set is applied after the clears so a newly issued producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr0_eff) busy_d[wr0_addr] = 1'b0;
    if (wr1_eff) busy_d[wr1_addr] = 1'b0;
    if (set_v)   busy_d[set_addr] = 1'b1;
    if (clr_all) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] a;
    logic          wr_hit;
    assign a      = rd_addr[i*AW +: AW];
    assign wr_hit = (wr0_eff && (wr0_addr == a)) || (wr1_eff && (wr1_addr == a));
    assign rd_busy[i] = en && busy_q[a] && !wr_hit && !((ZERO_REG != 0) && (a == '0));
  end

endmodule

// File: rtl/regbank_mp.sv
// Register bank with NRD read ports, two prioritised write ports, bypass and a clear sequencer.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NRD      = NRD_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  regbank_mp_if.slave  bus,
  output state_t       state_dbg
);

  localparam int AW = $clog2(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          in_ready;
  logic          wr0_eff, wr1_eff;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_CLEAR: begin
        if (bus.clr_req) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d   = ST_READY;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      ST_READY: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_idx_d = '0;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_READY);
  assign bus.ready = in_ready;
  assign state_dbg = state_q;

  assign wr0_eff = in_ready && bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
  assign wr1_eff = in_ready && bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));

  // Storage has no reset; the sequencer zeroes one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!in_ready) begin
      mem[clr_idx_q] <= '0;
    end else begin
      if (wr0_eff && !(wr1_eff && (bus.wr1_addr == bus.wr0_addr))) begin
        mem[bus.wr0_addr] <= bus.wr0_data;
      end
      if (wr1_eff) begin
        mem[bus.wr1_addr] <= bus.wr1_data;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] word;
    assign a = bus.rd_addr[i*AW +: AW];

    always_comb begin
      word = '0;
      if (!in_ready || ((ZERO_REG != 0) && (a == '0))) begin
        word = '0;
      end else if (wr1_eff && (bus.wr1_addr == a)) begin
        word = bus.wr1_data;
      end else if (wr0_eff && (bus.wr0_addr == a)) begin
        word = bus.wr0_data;
      end else begin
        word = mem[a];
      end
    end

    assign bus.rd_data[i*DW +: DW] = word;
  end

  regbank_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_all  (bus.clr_req),
    .en       (in_ready),
    .set_busy (bus.set_busy),
    .set_addr (bus.set_addr),
    .wr0_eff  (wr0_eff),
    .wr0_addr (bus.wr0_addr),
    .wr1_eff  (wr1_eff),
    .wr1_addr (bus.wr1_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

endmodule

// File: tb/tb_regbank_mp.sv
// Directed and randomised checks of the register bank: clear timing, write priority, bypass, pending bits.
module tb_regbank_mp;
  import regbank_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regbank_mp_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();
  state_t state_dbg;

  regbank_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [DW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic expect_port(input logic [DW-1:0] d, input logic b);
    exp_q.push_back({b, d});
  endtask

  task automatic sample(input string tag);
    logic [DW:0] e;
    #1;
    for (int p = 0; p < NRD; p++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s.p%0d.queue_empty", tag, p), 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s.p%0d.data", tag, p), 64'(bus.rd_data[p*DW +: DW]), 64'(e[DW-1:0]));
        check($sformatf("%s.p%0d.busy", tag, p), 64'(bus.rd_busy[p]), 64'(e[DW]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.clr_req  = 1'b0;
    bus.wr0_en   = 1'b0;
    bus.wr0_addr = '0;
    bus.wr0_data = '0;
    bus.wr1_en   = 1'b0;
    bus.wr1_addr = '0;
    bus.wr1_data = '0;
    bus.set_busy = 1'b0;
    bus.set_addr = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wr0(input int a, input logic [DW-1:0] d);
    bus.wr0_en = 1'b1; bus.wr0_addr = AW'(a); bus.wr0_data = d;
  endtask

  task automatic wr1(input int a, input logic [DW-1:0] d);
    bus.wr1_en = 1'b1; bus.wr1_addr = AW'(a); bus.wr1_data = d;
  endtask

  task automatic mark(input int a);
    bus.set_busy = 1'b1; bus.set_addr = AW'(a);
  endtask

  // Counts sampled cycles with ready=0, starting with the current one.
  task automatic wait_ready(input string tag);
    int cnt = 0;
    while (!bus.ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check(tag, 64'(cnt), 64'd32);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          a;
    logic [DW-1:0] d;
    idle();
    rd(5, 31);
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_CLEAR));
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("rst_rd");

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_ready("clear_len");
    check("ready_state", 64'(state_dbg), 64'(ST_READY));
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("ready_rd_r5_r31");

    // same-address writes: port 1 wins
    next_cycle(); wr0(3, 32'h1111); wr1(3, 32'h2222); rd(3, 0);
    expect_port(32'h2222, 1'b0); expect_port('0, 1'b0);
    sample("wr_prio_bypass");
    next_cycle(); rd(3, 0);
    expect_port(32'h2222, 1'b0); expect_port('0, 1'b0);
    sample("wr_prio_mem");

    // different addresses: both stored
    next_cycle(); wr0(10, 32'hAA); wr1(11, 32'hBB); rd(10, 11);
    expect_port(32'hAA, 1'b0); expect_port(32'hBB, 1'b0);
    sample("wr_both_bypass");
    next_cycle(); rd(10, 11);
    expect_port(32'hAA, 1'b0); expect_port(32'hBB, 1'b0);
    sample("wr_both_mem");

    // register 0 is hardwired
    next_cycle(); wr1(0, 32'hFFFF_FFFF); mark(0); rd(0, 3);
    expect_port('0, 1'b0); expect_port(32'h2222, 1'b0);
    sample("r0_write");
    next_cycle(); rd(0, 0);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("r0_after");

    // pending bit on r7, then cleared by its producer with bypass
    next_cycle(); mark(7); rd(7, 0);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("busy_issue");
    next_cycle(); rd(7, 0);
    expect_port('0, 1'b1); expect_port('0, 1'b0);
    sample("busy_set");
    wr0(7, 32'hABCD);
    expect_port(32'hABCD, 1'b0); expect_port('0, 1'b0);
    sample("busy_bypass");
    next_cycle(); rd(7, 0);
    expect_port(32'hABCD, 1'b0); expect_port('0, 1'b0);
    sample("busy_cleared");

    // set and clear same register: set wins
    next_cycle(); mark(9); wr1(9, 32'h5); rd(9, 7);
    expect_port(32'h5, 1'b0); expect_port(32'hABCD, 1'b0);
    sample("set_clr_same");
    next_cycle(); rd(9, 7);
    expect_port(32'h5, 1'b1); expect_port(32'hABCD, 1'b0);
    sample("set_wins");

    // random writes to untouched registers
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(12, 31);
      d = $urandom;
      next_cycle(); wr0(a, d); rd(a, 9);
      expect_port(d, 1'b0); expect_port(32'h5, 1'b1);
      sample($sformatf("rand%0d_bypass", i));
      next_cycle(); rd(a, 9);
      expect_port(d, 1'b0); expect_port(32'h5, 1'b1);
      sample($sformatf("rand%0d_mem", i));
    end

    // fill r1..r4 then request a clear
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); wr0(i, 32'h100 + i); rd(i, 0);
      expect_port(32'h100 + i, 1'b0); expect_port('0, 1'b0);
      sample($sformatf("fill_r%0d", i));
    end
    next_cycle(); bus.clr_req = 1'b1; rd(1, 9);
    expect_port(32'h101, 1'b0); expect_port(32'h5, 1'b1);
    sample("clr_req_cycle");
    next_cycle(); wr0(1, 32'h77); mark(2); rd(1, 2);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("in_clear_rd");
    check("in_clear_ready", 64'(bus.ready), 64'd0);
    wait_ready("clr_req_len");
    idle();
    rd(1, 2);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("after_clr_r1_r2");
    rd(3, 4);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("after_clr_r3_r4");
    rd(9, 7);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("after_clr_r9_r7");

    // asynchronous reset from READY
    next_cycle(); wr0(6, 32'h66);
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", 64'(bus.ready), 64'd0);
    check("rst_async_state", 64'(state_dbg), 64'(ST_CLEAR));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_ready("rst_len");
    rd(6, 0);
    expect_port('0, 1'b0); expect_port('0, 1'b0);
    sample("rst_recleared");

    // reset in the middle of a clear sequence restarts it in full
    next_cycle(); bus.clr_req = 1'b1;
    repeat (11) next_cycle();
    #1;
    check("mid_clear_ready", 64'(bus.ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_clear_rst_state", 64'(state_dbg), 64'(ST_CLEAR));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_ready("mid_clear_rst_len");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Next-generation register bank. It has parametrised data width, depth and read-port count, and two write ports with fixed priority.
- Write-to-read bypass is preserved.
- New: a hardware clear sequencer after reset or on request, and a per-register pending (scoreboard) bit for hazard detection.
- Sits in the decode stage and replaces the fixed 32x32 two-read/one-write bank.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, >= 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 reads as zero, is never written and is never pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_req  in  1  one-cycle pulse; restarts the clear sequence.
- ready  out  1  1 when the bank is usable (state READY).
- rd_addr  in  NRD*AW  read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRD*DW  combinational read data per port.
- rd_busy  out  NRD  per port: addressed register is pending.
- wr0_en  in  1  write port 0 enable.
- wr0_addr  in  AW  write port 0 address.
- wr0_data  in  DW  write port 0 data.
- wr1_en, wr1_addr, wr1_data  in  1/AW/DW  write port 1; higher priority than port 0.
- set_busy  in  1  mark a register pending (issue of a producer).
- set_addr  in  AW  register to mark.

Behaviour:
- Reset (rst_n=0, async): state=CLEAR, clr_idx=0, all busy bits=0, ready=0. Memory contents are not reset directly; the sequencer zeroes them.
- FSM, 2 states:
  - CLEAR: each cycle writes 0 to mem[clr_idx] and increments clr_idx. When clr_idx==DEPTH-1, the next state is READY, so CLEAR takes exactly DEPTH cycles.
  - READY: ready=1. clr_req=1 -> CLEAR with clr_idx=0 and all busy bits cleared on the same edge.
  - clr_req during CLEAR restarts clr_idx at 0.
- While in CLEAR:
  - wr0/wr1/set_busy are ignored.
  - rd_data=0 and rd_busy=0 on all ports.
- Writes (READY only):
  - Effective port k = wrk_en && !(ZERO_REG && wrk_addr==0).
  - Both effective and same address: wr1 data is stored, wr0 is dropped.
  - Different addresses: both are stored on the same edge.
- Read, per port i, combinational, in priority order:
  1. ZERO_REG && addr==0 -> 0.
  2. Effective wr1 to addr -> wr1_data.
  3. Effective wr0 to addr -> wr0_data.
  4. Otherwise mem[addr].
- Scoreboard (READY only):
  - An effective write to addr clears busy[addr] on the edge.
  - set_busy sets busy[set_addr], but not for register 0 when ZERO_REG.
  - Set and clear of the same register in the same cycle: set wins (a newer producer is issued).
  - rd_busy[i] = busy[rd_addr_i] && !(an effective write to rd_addr_i this cycle). The bypass covers the value, so no stall is needed.
  - rd_busy for register 0 is always 0 when ZERO_REG.
- Latency: reads and bypass have 0 cycles; writes and busy updates are visible from the next cycle.
- Reset mid-CLEAR or mid-operation: immediate return to CLEAR with idx 0. Partially cleared contents are re-cleared.

Decomposition:
- Shared package regbank_pkg: FSM state enum (ST_CLEAR, ST_READY) and the parameter defaults.
- One sub-module, regbank_scoreboard: busy vector with set/clear priority and per-port lookup.
- Storage, bypass and FSM stay in the top module.

Test Plan:
- Release rst_n, hold all inputs 0 -> ready=0 for exactly DEPTH (32) cycles, then 1; reads of r5 and r31 return 0 in both states.
- READY, wr0 r3=0x1111 and wr1 r3=0x2222 in the same cycle, read r3 on port 0 -> 0x2222 combinationally that cycle; next cycle mem r3=0x2222.
- Write r0=0xFFFF_FFFF on wr1 -> read r0 returns 0; set_busy r0 -> rd_busy 0.
- set_busy r7; next cycle read r7 -> rd_busy=1. wr0 r7=0xABCD that cycle -> rd_data=0xABCD, rd_busy=0; following cycle busy[r7]=0.
- Same-cycle set_busy r9 and wr1 r9=0x5 -> next cycle rd_busy for r9=1, data=0x5.
- Fill r1..r4, pulse clr_req, attempt wr0 r1=0x77 during CLEAR -> ignored; after 32 cycles ready=1 and r1..r4 read 0. Assert rst_n=0 mid-sequence -> ready drops immediately, full 32-cycle clear restarts.
